// File: rtl/vin_adc_scheduler.sv
// rtl/vin_adc_scheduler.sv - round-robin 4-channel ADC conversion scheduler (optional averaging: VIN_ADC_SCHED_AVG_EN)
module vin_adc_scheduler #(
  parameter logic [15:0] GAP_CYCLES    = 16'd1000,
  parameter logic [15:0] START_TIMEOUT = 16'd255,
  parameter logic [23:0] CONV_TIMEOUT  = 24'd2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  chan_mask,
  input  logic        err_clear,
  output logic        adc_enable,
  output logic [1:0]  adc_channel,
  input  logic [15:0] adc_data,
  input  logic        adc_ready,
  output logic [31:0] adc0,
  output logic [31:0] adc1,
  output logic [31:0] adc2,
  output logic [31:0] adc3,
  output logic [3:0]  sample_valid,
  output logic [3:0]  timeout_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, SELECT, WAIT_START, WAIT_DONE, RELEASE, GAP
  } state_t;

  state_t           state, stateNext;
  logic [1:0]       lastCh;
  logic [1:0]       nextCh;
  logic             nextValid;
  logic [23:0]      wdCnt;
  logic [15:0]      gapCnt;
  logic             capture;
  logic             timeoutHit;
  logic [11:0]      clamped;
  logic [3:0][11:0] resultReg;
  logic             unusedLowBits;

  // Negative engine readings clamp to zero; otherwise keep the 12-bit window below the sign bit.
  assign clamped       = adc_data[15] ? 12'd0 : adc_data[14:3];
  assign unusedLowBits = ^adc_data[2:0];

  assign adc0 = {20'd0, resultReg[0]};
  assign adc1 = {20'd0, resultReg[1]};
  assign adc2 = {20'd0, resultReg[2]};
  assign adc3 = {20'd0, resultReg[3]};
  assign busy = (state != IDLE);

  // Pick the first enabled channel after the last served one; lastCh itself has lowest priority.
  always_comb begin
    logic [1:0] cand;
    cand      = 2'd0;
    nextCh    = lastCh;
    nextValid = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      cand = lastCh + 2'(i);
      if (chan_mask[cand]) begin
        nextCh    = cand;
        nextValid = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic plus capture/timeout strobes.
  always_comb begin
    stateNext  = state;
    capture    = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE:       if (chan_mask != 4'd0) stateNext = SELECT;
      SELECT:     stateNext = nextValid ? WAIT_START : IDLE;
      WAIT_START: begin
        if (!adc_ready) begin
          stateNext = WAIT_DONE;
        end else if (wdCnt == {8'd0, START_TIMEOUT}) begin
          timeoutHit = 1'b1;
          stateNext  = RELEASE;
        end
      end
      WAIT_DONE: begin
        if (adc_ready) begin
          capture   = 1'b1;
          stateNext = RELEASE;
        end else if (wdCnt == CONV_TIMEOUT) begin
          timeoutHit = 1'b1;
          stateNext  = RELEASE;
        end
      end
      RELEASE:    stateNext = (GAP_CYCLES == 16'd0) ? SELECT : GAP;
      GAP:        if (gapCnt == GAP_CYCLES - 16'd1) stateNext = SELECT;
      default:    stateNext = IDLE;
    endcase
  end

  // Engine request handshake, watchdog and inter-conversion gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastCh      <= 2'd3;
      adc_channel <= 2'd0;
      adc_enable  <= 1'b0;
      wdCnt       <= 24'd0;
      gapCnt      <= 16'd0;
    end else begin
      if (state == SELECT) wdCnt <= 24'd0;
      else if (state == WAIT_START) wdCnt <= adc_ready ? wdCnt + 24'd1 : 24'd0;
      else if (state == WAIT_DONE) wdCnt <= wdCnt + 24'd1;

      if (state == SELECT && nextValid) begin
        adc_channel <= nextCh;
        lastCh      <= nextCh;
        adc_enable  <= 1'b1;
      end else if (stateNext == RELEASE) begin
        adc_enable <= 1'b0;
      end

      if (state == RELEASE) gapCnt <= 16'd0;
      else if (state == GAP) gapCnt <= gapCnt + 16'd1;
    end
  end

  // Sticky per-channel watchdog flags; a fresh timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err <= 4'd0;
    else     timeout_err <= (err_clear ? 4'd0 : timeout_err) |
                            (timeoutHit ? (4'b0001 << adc_channel) : 4'd0);
  end

`ifdef VIN_ADC_SCHED_AVG_EN
  logic [3:0][13:0] accSum;
  logic [3:0][1:0]  accCnt;
  logic [3:0]       maskPrev;
  logic [13:0]      sumNew;

  assign sumNew = accSum[adc_channel] + {2'b00, clamped};

  // Four-sample averaging per channel; any mask change or a timeout discards partial sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultReg    <= '0;
      sample_valid <= 4'd0;
      accSum       <= '0;
      accCnt       <= '0;
      maskPrev     <= 4'd0;
    end else begin
      sample_valid <= 4'd0;
      maskPrev     <= chan_mask;
      if (chan_mask != maskPrev) begin
        accSum <= '0;
        accCnt <= '0;
      end else if (capture) begin
        if (accCnt[adc_channel] == 2'd3) begin
          resultReg[adc_channel]    <= sumNew[13:2];
          sample_valid[adc_channel] <= 1'b1;
          accSum[adc_channel]       <= 14'd0;
          accCnt[adc_channel]       <= 2'd0;
        end else begin
          accSum[adc_channel] <= sumNew;
          accCnt[adc_channel] <= accCnt[adc_channel] + 2'd1;
        end
      end else if (timeoutHit) begin
        accSum[adc_channel] <= 14'd0;
        accCnt[adc_channel] <= 2'd0;
      end
    end
  end
`else
  // Every capture publishes straight to the channel's result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultReg    <= '0;
      sample_valid <= 4'd0;
    end else begin
      sample_valid <= 4'd0;
      if (capture) begin
        resultReg[adc_channel]    <= clamped;
        sample_valid[adc_channel] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vin_adc_scheduler.sv
// tb/tb_vin_adc_scheduler.sv - scoreboard bench for vin_adc_scheduler with randomized engine model
module tb_vin_adc_scheduler;
  localparam logic [15:0] GAP = 16'd2;
  localparam logic [15:0] STO = 16'd255;
  localparam logic [23:0] CTO = 24'd300;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  chan_mask;
  logic        err_clear;
  logic        adc_enable;
  logic [1:0]  adc_channel;
  logic [15:0] adc_data;
  logic        adc_ready;
  logic [31:0] adc0, adc1, adc2, adc3;
  logic [3:0]  sample_valid;
  logic [3:0]  timeout_err;
  logic        busy;

  always #5 clk = ~clk;

  vin_adc_scheduler #(.GAP_CYCLES(GAP), .START_TIMEOUT(STO), .CONV_TIMEOUT(CTO)) dut (
    .clk(clk), .rst(rst), .chan_mask(chan_mask), .err_clear(err_clear),
    .adc_enable(adc_enable), .adc_channel(adc_channel), .adc_data(adc_data), .adc_ready(adc_ready),
    .adc0(adc0), .adc1(adc1), .adc2(adc2), .adc3(adc3),
    .sample_valid(sample_valid), .timeout_err(timeout_err), .busy(busy)
  );

  int       cmpCount = 0;
  int       failCount = 0;
  int       expQ[$];
  int       dataQ[$];
  int       hangNext = 0;
  int       reqDone = 0;
  bit       engBusy = 1'b0;
  logic [3:0] expErr = 4'd0;
  int       modelLast = 3;
  int       pulseCnt[4] = '{0, 0, 0, 0};
  int       snap[4];
`ifdef VIN_ADC_SCHED_AVG_EN
  int       accS[4] = '{0, 0, 0, 0};
  int       accN[4] = '{0, 0, 0, 0};
`endif

  task automatic check(input string name, input int act, input int req);
    cmpCount++;
    if (act !== req) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int clampModel(input int d);
    if (d >= 32768) return 0;
    return d / 8;
  endfunction

  function automatic int predictNext(input int mask);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (modelLast + k) % 4;
      if ((mask >> c) & 1) return c;
    end
    return -1;
  endfunction

  function automatic int adcVal(input int n);
    case (n)
      0: return int'(adc0);
      1: return int'(adc1);
      2: return int'(adc2);
      default: return int'(adc3);
    endcase
  endfunction

  task automatic modelCapture(input int ch, input int v);
`ifdef VIN_ADC_SCHED_AVG_EN
    accS[ch] += v;
    accN[ch]++;
    if (accN[ch] == 4) begin
      expQ.push_back((ch << 16) | (accS[ch] / 4));
      accS[ch] = 0;
      accN[ch] = 0;
    end
`else
    expQ.push_back((ch << 16) | v);
`endif
  endtask

  task automatic modelDrop(input int ch);
`ifdef VIN_ADC_SCHED_AVG_EN
    accS[ch] = 0;
    accN[ch] = 0;
`else
    if (ch < 0) $display("note: dropped unknown channel");
`endif
  endtask

  task automatic setMask(input logic [3:0] m);
`ifdef VIN_ADC_SCHED_AVG_EN
    if (m != chan_mask) for (int i = 0; i < 4; i++) begin accS[i] = 0; accN[i] = 0; end
`endif
    chan_mask = m;
  endtask

  task automatic waitEnableLow(input int budget, output int n);
    n = 0;
    while (adc_enable === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (adc_enable !== 1'b0) check("enable_release_timeout", int'(adc_enable), 0);
  endtask

  task automatic waitReq(input int target);
    int n;
    n = 0;
    while (reqDone < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("request_progress", int'(reqDone >= target), 1);
  endtask

  task automatic waitBusy();
    int n;
    n = 0;
    while (!engBusy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("engine_busy_seen", int'(engBusy), 1);
  endtask

  // Engine model: answers each request, records expected results and timeout flags.
  initial begin : engine
    int ch, mode, data, n;
    adc_ready = 1'b1;
    adc_data  = 16'd0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && adc_enable === 1'b1 && adc_ready === 1'b1) begin
        ch = predictNext(int'(chan_mask));
        check("channel_order", int'(adc_channel), ch);
        if (ch >= 0) modelLast = ch;
        mode = hangNext;
        hangNext = 0;
        data = (dataQ.size() > 0) ? dataQ.pop_front() : int'($urandom_range(0, 65535));
        if (mode == 1) begin
          waitEnableLow(2000, n);
          check("start_timeout_cycles", n, int'(STO) + 1);
          expErr[ch] = 1'b1;
          modelDrop(ch);
          check("timeout_err_start", int'(timeout_err), int'(expErr));
        end else begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          adc_ready = 1'b0;
          engBusy   = 1'b1;
          if (mode == 2) begin
            waitEnableLow(int'(CTO) + 50, n);
            expErr[ch] = 1'b1;
            modelDrop(ch);
            check("timeout_err_conv", int'(timeout_err), int'(expErr));
            adc_ready = 1'b1;
            engBusy   = 1'b0;
          end else begin
            repeat ($urandom_range(2, 12)) @(negedge clk);
            adc_data  = data[15:0];
            adc_ready = 1'b1;
            engBusy   = 1'b0;
            modelCapture(ch, clampModel(data));
            waitEnableLow(50, n);
          end
        end
        reqDone++;
      end
    end
  end

  // Scoreboard monitor: every published sample must match the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int n = 0; n < 4; n++) begin
        if (sample_valid[n]) begin
          pulseCnt[n]++;
          if (expQ.size() == 0) begin
            cmpCount++;
            failCount++;
            $display("FAIL unexpected_sample: ch %0d value 0x%0h, expected no sample", n, adcVal(n));
          end else begin
            int e;
            e = expQ.pop_front();
            check("sample_channel", n, e >> 16);
            check("sample_value", adcVal(n), e & 16'hFFFF);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int t;
    rst = 1'b1;
    chan_mask = 4'b0001;
    err_clear = 1'b0;
    repeat (3) dataQ.push_back(16'h4000);
    repeat (3) @(negedge clk);
    check("rst_enable", int'(adc_enable), 0);
    check("rst_channel", int'(adc_channel), 0);
    check("rst_adc0", int'(adc0), 0);
    check("rst_adc3", int'(adc3), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_err", int'(timeout_err), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("latency_edge1", int'(adc_enable), 0);
    @(negedge clk);
    check("latency_edge2", int'(adc_enable), 1);

    waitReq(3);
    @(negedge clk);
`ifndef VIN_ADC_SCHED_AVG_EN
    check("single_ch_adc0", int'(adc0), 32'h800);
`endif
    check("single_ch_adc1", int'(adc1), 0);
    check("single_ch_adc2", int'(adc2), 0);
    check("single_ch_adc3", int'(adc3), 0);

    waitBusy();
    setMask(4'b1011);
    waitReq(4);
    @(negedge clk);
    snap = pulseCnt;
    waitReq(10);
    @(negedge clk);
`ifndef VIN_ADC_SCHED_AVG_EN
    check("rr_pulses_ch0", pulseCnt[0] - snap[0], 2);
    check("rr_pulses_ch1", pulseCnt[1] - snap[1], 2);
    check("rr_pulses_ch3", pulseCnt[3] - snap[3], 2);
`endif
    check("rr_pulses_ch2", pulseCnt[2] - snap[2], 0);

    waitBusy();
    setMask(4'b0100);
    dataQ.push_back(16'h8010);
    dataQ.push_back(16'h7FFF);
    waitReq(12);
    @(negedge clk);
`ifndef VIN_ADC_SCHED_AVG_EN
    check("clamp_negative", int'(adc2), 0);
`endif
    waitReq(13);
    @(negedge clk);
`ifndef VIN_ADC_SCHED_AVG_EN
    check("clamp_max", int'(adc2), 32'hFFF);
`endif

    waitBusy();
    setMask(4'b0110);
    hangNext = 1;
    waitReq(15);
    hangNext = 2;
    waitReq(16);
    @(negedge clk);
    check("timeout_err_both", int'(timeout_err), 4'b0110);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    expErr = 4'd0;
    @(negedge clk);
    check("err_clear", int'(timeout_err), 0);
    waitReq(18);

    waitBusy();
    setMask(4'b0000);
    t = reqDone + 1;
    waitReq(t);
    repeat (5) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_enable", int'(adc_enable), 0);
    check("idle_no_request", reqDone, t);
    check("idle_scoreboard_empty", expQ.size(), 0);

    setMask(4'($urandom_range(1, 15)));
    for (int i = 0; i < 20; i++) begin
      waitBusy();
      if ($urandom_range(0, 2) == 0) setMask(4'($urandom_range(1, 15)));
      if ($urandom_range(0, 9) == 0) hangNext = 1;
      t = reqDone + 1;
      waitReq(t);
    end
    waitBusy();
    setMask(4'b0000);
    t = reqDone + 1;
    waitReq(t);
    repeat (5) @(negedge clk);
    check("final_scoreboard_empty", expQ.size(), 0);
    check("final_err", int'(timeout_err), int'(expErr));

    setMask(4'b0001);
    waitBusy();
    rst = 1'b1;
    #1;
    check("async_reset_enable", int'(adc_enable), 0);
    check("async_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end
endmodule
